// File: rtl/dct2d_if.sv
// dct2d_if: coefficient-load and raster sample stream ports of the 2-D transform engine
interface dct2d_if #(
  parameter int N     = 8,
  parameter int IN_W  = 9,
  parameter int CW    = 12,
  parameter int OUT_W = 16
);
  localparam int AW = 2 * $clog2(N);
  logic                    coef_we;
  logic [AW-1:0]           coef_addr;
  logic signed [CW-1:0]    coef_data;
  logic                    mode;
  logic                    in_valid;
  logic                    in_ready;
  logic signed [IN_W-1:0]  in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [OUT_W-1:0] out_data;
  logic                    out_last;
  logic                    busy;
  modport master (
    output coef_we, coef_addr, coef_data, mode, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last, busy
  );
  modport slave (
    input  coef_we, coef_addr, coef_data, mode, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last, busy
  );
endinterface

// File: rtl/dct2d_engine.sv
// dct2d_engine: single-MAC separable 2-D transform, Y = C*X*C^T (mode 0) or C^T*X*C (mode 1)
module dct2d_engine #(
  parameter int N     = 8,
  parameter int IN_W  = 9,
  parameter int CW    = 12,
  parameter int FRAC  = 10,
  parameter int MID_W = 16,
  parameter int OUT_W = 16
) (
  input  logic   clk,
  input  logic   rst,
  dct2d_if.slave io
);
  localparam int LN = $clog2(N);
  localparam int NN = N * N;
  localparam int PW = CW + MID_W;
  localparam int AW = PW + LN + 1;
  localparam logic signed [AW-1:0] HALF   = AW'(1) <<< (FRAC - 1);
  localparam logic signed [AW-1:0] MID_HI = {{(AW-MID_W+1){1'b0}}, {(MID_W-1){1'b1}}};
  localparam logic signed [AW-1:0] MID_LO = ~MID_HI;
  localparam logic signed [AW-1:0] OUT_HI = {{(AW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [AW-1:0] OUT_LO = ~OUT_HI;
  typedef enum logic [1:0] {LOAD, PASS1, PASS2, DRAIN} state_t;
  state_t state, state_n;
  logic [2*LN-1:0] idx;
  logic [3*LN-1:0] cnt;
  logic [LN-1:0] ci, cj, ck, sel;
  logic rdy, mode_q, in_fire, out_fire, mac, k_end;
  logic signed [CW-1:0]    c_mem [NN];
  logic signed [IN_W-1:0]  x_mem [NN];
  logic signed [MID_W-1:0] t_mem [NN];
  logic signed [OUT_W-1:0] y_mem [NN];
  logic signed [CW-1:0]    op_c;
  logic signed [MID_W-1:0] op_d, t_sat;
  logic signed [OUT_W-1:0] y_sat;
  logic signed [PW-1:0]    prod;
  logic signed [AW-1:0]    acc, sum, rnd;

  assign {ci, cj, ck} = cnt;
  assign mac          = state == PASS1 || state == PASS2;
  assign k_end        = &ck;
  assign in_fire      = io.in_ready && io.in_valid;
  assign out_fire     = io.out_valid && io.out_ready;
  assign io.in_ready  = state == LOAD && rdy;
  assign io.out_valid = state == DRAIN;
  assign io.out_last  = io.out_valid && &idx;
  assign io.out_data  = io.out_valid ? y_mem[idx] : '0;
  assign io.busy      = state != LOAD || idx != '0;

  // Every MAC is coefficient * data; the mode only swaps which C index walks with k.
  always_comb begin
    sel   = state == PASS1 ? ci : cj;
    op_c  = mode_q ? c_mem[{ck, sel}] : c_mem[{sel, ck}];
    op_d  = state == PASS1 ? MID_W'(x_mem[{ck, cj}]) : t_mem[{ci, ck}];
    prod  = PW'(op_c) * PW'(op_d);
    sum   = acc + AW'(prod);
    rnd   = (sum + HALF) >>> FRAC;
    t_sat = rnd > MID_HI ? MID_HI[MID_W-1:0] : rnd < MID_LO ? MID_LO[MID_W-1:0] : rnd[MID_W-1:0];
    y_sat = rnd > OUT_HI ? OUT_HI[OUT_W-1:0] : rnd < OUT_LO ? OUT_LO[OUT_W-1:0] : rnd[OUT_W-1:0];
  end

  always_comb begin
    state_n = state;
    state_n = state == LOAD  ? (in_fire && &idx ? PASS1 : LOAD) :
              state == PASS1 ? (&cnt ? PASS2 : PASS1) :
              state == PASS2 ? (&cnt ? DRAIN : PASS2) :
                               (out_fire && &idx ? LOAD : DRAIN);
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state  <= LOAD;
      idx    <= '0;
      cnt    <= '0;
      acc    <= '0;
      rdy    <= 1'b0;
      mode_q <= 1'b0;
    end else begin
      state <= state_n;
      rdy   <= 1'b1;
      if (in_fire && idx == '0) mode_q <= io.mode;
      if (in_fire || out_fire) idx <= idx + 1'b1;
      if (mac) begin
        cnt <= cnt + 1'b1;
        acc <= k_end ? '0 : sum;
      end
    end

  always_ff @(posedge clk) begin
    if (io.coef_we && !io.busy) c_mem[io.coef_addr] <= io.coef_data;
    if (in_fire) x_mem[idx] <= io.in_data;
    if (state == PASS1 && k_end) t_mem[{ci, cj}] <= t_sat;
    if (state == PASS2 && k_end) y_mem[{ci, cj}] <= y_sat;
  end
endmodule

// File: tb/tb_dct2d_engine.sv
// tb_dct2d_engine: directed and random blocks checked against a matrix-level reference model
module tb_dct2d_engine;
  localparam int N    = 8;
  localparam int NN   = N * N;
  localparam int FRAC = 10;
  logic clk = 0;
  logic rst = 1;
  dct2d_if bus();
  dct2d_engine dut (.clk(clk), .rst(rst), .io(bus));
  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  int cm[NN], xm[NN], got[NN], ref_y[NN];
  longint exp_y[NN];
  int cyc = 0, acc_cyc = 0, oidx = 0, blocks_done = 0;
  bit bp = 0, lat_chk = 0, stall_prev = 0, hold_last = 0;
  longint hold_d = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic longint rs(input longint s, input int w);
    longint hi = (longint'(1) <<< (w - 1)) - 1;
    longint v = (s + (longint'(1) <<< (FRAC - 1))) >>> FRAC;
    return v > hi ? hi : (v < -hi - 1 ? -hi - 1 : v);
  endfunction

  task automatic model(input bit m);
    longint t[NN];
    longint s;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        s = 0;
        for (int k = 0; k < N; k++) s += longint'(m ? cm[k*N+i] : cm[i*N+k]) * xm[k*N+j];
        t[i*N+j] = rs(s, 16);
      end
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        s = 0;
        for (int k = 0; k < N; k++) s += t[i*N+k] * (m ? cm[k*N+j] : cm[j*N+k]);
        exp_y[i*N+j] = rs(s, 16);
      end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1 bus.out_ready = bp ? ($urandom_range(0, 99) < 30) : 1'b1;
  end

  always @(negedge clk) begin
    if (!rst && bus.out_valid) begin
      if (!lat_chk) chk("latency", cyc - acc_cyc, 2 * N * N * N);
      lat_chk = 1;
      chk("in_ready_in_drain", bus.in_ready, 0);
      if (stall_prev) begin
        chk("hold_data", bus.out_data, hold_d);
        chk("hold_last", bus.out_last, hold_last);
      end
      stall_prev = !bus.out_ready;
      hold_d = bus.out_data;
      hold_last = bus.out_last;
      if (bus.out_ready) begin
        chk($sformatf("y[%0d]", oidx), bus.out_data, exp_y[oidx]);
        chk($sformatf("last[%0d]", oidx), bus.out_last, oidx == NN - 1);
        got[oidx] = bus.out_data;
        oidx++;
        if (oidx == NN) begin
          oidx = 0;
          blocks_done++;
          lat_chk = 0;
        end
      end
    end else stall_prev = 0;
  end

  task automatic set_c();
    for (int a = 0; a < NN; a++) begin
      bus.coef_we = 1;
      bus.coef_addr = 6'(a);
      bus.coef_data = 12'(cm[a]);
      @(posedge clk); #1;
    end
    bus.coef_we = 0;
  endtask

  task automatic send(input bit m, input bit wr_first);
    int n = 0, guard = 0;
    int wa = $urandom_range(0, NN - 1);
    int wv = int'($urandom_range(0, 4095)) - 2048;
    bit fired;
    while (n < NN && guard < 4 * NN) begin
      bus.in_valid = n == 0 || $urandom_range(0, 3) != 0;
      bus.in_data = 9'(xm[n]);
      bus.mode = (n == 0) ? m : !m;
      bus.coef_we = wr_first && n == 0 && guard == 0;
      if (bus.coef_we) begin
        bus.coef_addr = 6'(wa);
        bus.coef_data = 12'(wv);
        cm[wa] = wv;
      end
      @(negedge clk);
      fired = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
      bus.coef_we = 0;
      if (fired) n++;
      guard++;
    end
    bus.in_valid = 0;
    acc_cyc = cyc;
    chk("send_done", n, NN);
    chk("in_ready_after_last", bus.in_ready, 0);
    chk("busy_after_last", bus.busy, 1);
  endtask

  task automatic wait_done();
    int b0 = blocks_done, t = 0;
    while (blocks_done == b0 && t < 4000) begin
      @(posedge clk);
      t++;
    end
    #1;
    chk("block_done", blocks_done - b0, 1);
    chk("out_valid_after_drain", bus.out_valid, 0);
  endtask

  task automatic run(input bit m, input bit wr_first, input bit busy_wr);
    send(m, wr_first);
    model(m);
    if (busy_wr)
      for (int w = 0; w < 5; w++) begin
        bus.coef_we = 1;
        bus.coef_addr = 6'($urandom_range(0, NN - 1));
        bus.coef_data = 12'($urandom_range(0, 4095));
        @(negedge clk);
        chk("busy_during_write", bus.busy, 1);
        @(posedge clk); #1;
      end
    bus.coef_we = 0;
    wait_done();
  endtask

  task automatic rand_block();
    for (int a = 0; a < NN; a++) begin
      cm[a] = int'($urandom_range(0, 4095)) - 2048;
      xm[a] = int'($urandom_range(0, 511)) - 256;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    bit m;
    bus.coef_we = 0; bus.coef_addr = 0; bus.coef_data = 0; bus.mode = 0;
    bus.in_valid = 0; bus.in_data = 0; bus.out_ready = 1;
    #2;
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_last", bus.out_last, 0);
    chk("rst_busy", bus.busy, 0);
    #11 rst = 0;
    #1 chk("in_ready_before_clk", bus.in_ready, 0);
    @(posedge clk); #1;
    chk("in_ready_after_rst", bus.in_ready, 1);

    for (int a = 0; a < NN; a++) begin cm[a] = (a / N == a % N) ? 1024 : 0; xm[a] = a - 32; end
    set_c(); run(0, 0, 0);
    chk("id_y0", got[0], -32); chk("id_y9", got[9], -23); chk("id_y63", got[63], 31);

    for (int a = 0; a < NN; a++) begin cm[a] = a < N ? 1024 : 0; xm[a] = 100; end
    set_c(); run(0, 0, 0);
    chk("dc_y0", got[0], 6400); chk("dc_y1", got[1], 0); chk("dc_y63", got[63], 0);

    for (int a = 0; a < NN; a++) begin cm[a] = (a % N == (a / N + 1) % N) ? 1024 : 0; xm[a] = a; end
    set_c(); run(0, 0, 0);
    chk("fwd_y0", got[0], 9); chk("fwd_y19", got[19], 28); chk("fwd_y63", got[63], 0);
    run(1, 0, 0);
    chk("inv_y0", got[0], 63); chk("inv_y9", got[9], 0); chk("inv_y19", got[19], 10);

    for (int a = 0; a < NN; a++) begin cm[a] = 2047; xm[a] = 255; end
    set_c(); run(0, 0, 0);
    chk("sat_y0", got[0], 32767); chk("sat_y63", got[63], 32767);

    for (int a = 0; a < NN; a++) begin cm[a] = (a / N == a % N) ? 1024 : 0; xm[a] = 1; end
    cm[0] = 512; xm[1] = -1;
    set_c(); run(0, 0, 0);
    chk("rnd_y0", got[0], 1); chk("rnd_y1", got[1], 0); chk("rnd_y2", got[2], 1); chk("rnd_y9", got[9], 1);

    rand_block(); m = 1'($urandom_range(0, 1));
    set_c(); run(m, 1, 0);
    ref_y = got;
    bp = 1; run(m, 0, 0); bp = 0;
    for (int a = 0; a < NN; a++) chk($sformatf("bp_same[%0d]", a), got[a], ref_y[a]);

    rand_block(); m = 1'($urandom_range(0, 1));
    set_c(); run(m, 0, 1); run(!m, 0, 0);

    send(m, 0);
    repeat (100) @(posedge clk);
    #3 rst = 1;
    #1 chk("midrst_in_ready", bus.in_ready, 0);
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_busy", bus.busy, 0);
    #2 rst = 0;
    @(posedge clk); #1;
    chk("postrst_in_ready", bus.in_ready, 1);
    chk("postrst_out_valid", bus.out_valid, 0);
    run(m, 0, 0);

    for (int r = 0; r < 3; r++) begin
      rand_block();
      set_c();
      bp = 1'(r);
      run(1'($urandom_range(0, 1)), 0, 0);
    end
    bp = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/dct2d_engine.md
Name: dct2d_engine

Overview:
- Parametrised, sequential 2-D separable transform engine for N×N blocks.
- Computes Y = C·X·Cᵀ (forward, mode 0) or Y = Cᵀ·X·C (inverse, mode 1) with a runtime-loadable coefficient matrix C.
- Samples are streamed in and out in raster order over valid/ready handshakes.
- One time-shared MAC per cycle. Sits between the block splitter and the quantiser (forward) or dequantiser and block merger (inverse).

Parameters:
- N, 8, block dimension; power of two, 2..16.
- IN_W, 9, signed input sample width.
- CW, 12, signed coefficient width.
- FRAC, 10, coefficient fractional bits (1.0 = 2^FRAC).
- MID_W, 16, signed intermediate T width (saturated).
- OUT_W, 16, signed output width (saturated).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  2*log2(N)  row*N+col of C.
- coef_data  in  CW  signed coefficient.
- mode  in  1  0 = forward, 1 = inverse; sampled with first accepted sample of a block.
- in_valid  in  1  input sample valid.
- in_ready  out  1  engine accepts sample.
- in_data  in  IN_W  signed sample, raster order.
- out_valid  out  1  output sample valid.
- out_ready  in  1  downstream accepts.
- out_data  out  OUT_W  signed result, raster order.
- out_last  out  1  marks sample (N-1,N-1).
- busy  out  1  high in any state other than LOAD with zero samples accepted.

Behaviour:
- Reset (async, rst=1):
  - State = LOAD; all counters = 0.
  - in_ready = 0 while rst is high, 1 from the first clock after rst falls.
  - out_valid = 0, out_last = 0, out_data = 0, busy = 0.
  - C contents are not reset and hold their last written value; X/T/Y buffers are don't-care.
- Coefficient write:
  - Performed on a clock edge with coef_we=1 and busy=0.
  - Ignored while busy=1.
  - A write in the same cycle as the first accepted sample is performed and is used for that block.
- States:
  - LOAD: in_ready=1. Each in_valid&in_ready stores in_data at X[idx], idx++. Mode is latched on idx==0. When idx reaches N²-1 and is accepted -> PASS1.
  - PASS1: in_ready=0. One MAC per cycle over i,j,k (k innermost).
    - Forward: T[i][j] = Σk C[i][k]·X[k][j].
    - Inverse: T[i][j] = Σk C[k][i]·X[k][j].
    - N³ cycles, then -> PASS2.
  - PASS2:
    - Forward: Y[i][j] = Σk T[i][k]·C[j][k].
    - Inverse: Y[i][j] = Σk T[i][k]·C[k][j].
    - N³ cycles, then -> DRAIN.
  - DRAIN: out_valid=1 presenting Y in raster order. Advance on out_valid&out_ready; out_data and out_last are held stable while out_ready=0. After (N-1,N-1) is accepted -> LOAD, out_valid=0 next cycle.
- Arithmetic:
  - Accumulator is full precision (no internal overflow).
  - At the end of each k-sum: add 2^(FRAC-1), arithmetic shift right by FRAC (round half up), then saturate to MID_W (pass 1) or OUT_W (pass 2) signed range.
- Latency: the first output is valid exactly 2·N³ cycles after the cycle the last input is accepted (N=8: 1024). Minimum block period is N² + 2·N³ + N² cycles.
- Single-buffered: no input is accepted during PASS1, PASS2 or DRAIN.
- in_valid with in_ready=0 has no effect. in_data is ignored when in_valid=0.
- Reset asserted mid-block: the block is abandoned and no partial output is produced.

Test Plan:
- Identity: C = 1024·I, mode 0, X[r][c] = r·8+c-32 -> Y == X bit-exact; out_last only on the 64th sample; in_ready low from acceptance of sample 63 until DRAIN completes.
- DC: C row 0 = 1024, all other rows 0, X all 100 -> Y[0][0]=6400, all other Y=0; first out_valid exactly 1024 cycles after last input accepted.
- Mode discrimination: C[i][(i+1)%8] = 1024, X[r][c] = r·8+c.
  - Mode 0 -> Y[i][j] = X[(i+1)%8][(j+1)%8].
  - Mode 1 -> Y[i][j] = X[(i-1)%8][(j-1)%8].
- Saturation and rounding: C all 2047, X all 255 -> T=4078, Y all 32767. Separate run: C=1024·I with one coefficient at 512, X value 1 -> rounds 0.5 up to 1.
- Backpressure: random out_ready (~30% duty) during DRAIN -> output sequence identical to the unstalled run; out_data stable whenever out_valid&!out_ready.
- Reset and write gating:
  - rst pulse mid-PASS1 (async, between edges) -> out_valid=0, in_ready=1 after release; next block correct with C unchanged.
  - coef_we during busy is ignored; a following block uses the old C.
